mul_div_wb_arbiter: RTL and testbench
=====================================

Name: mul_div_wb_arbiter

Overview:
Shares the single mul/div writeback (CDB) port between the multiplier and divider functional units.
- Captures each unit's single-cycle result pulse into a 1-entry per-source hold register.
- Arbitrates the two hold registers onto the writeback port.
- Back-pressures issue per unit.
- Discards results of operations in flight when the pipeline is flushed.

Sits between fu_mul/fu_div outputs and the ROB/physical-register writeback bus.

Parameters:
WORD_WIDTH, 32, result data width
PADDR_WIDTH, 5, physical destination (ROB index) width, = $clog2(ROB_DEPTH)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush (mispredict/exception), synchronous
mul_issue_fire  input  1  mul op accepted by multiplier this cycle
div_issue_fire  input  1  div op accepted by divider this cycle
mul_out_valid  input  1  multiplier result pulse
mul_out  input  WORD_WIDTH  multiplier result
mul_dst_Paddr  input  PADDR_WIDTH  multiplier destination
div_out_valid  input  1  divider result pulse
div_out  input  WORD_WIDTH  divider result
div_dst_Paddr  input  PADDR_WIDTH  divider destination
wb_ready  input  1  writeback port accepts this cycle
wb_valid  output  1  writeback request
wb_data  output  WORD_WIDTH  writeback data
wb_Paddr  output  PADDR_WIDTH  writeback destination
wb_src  output  1  0 = mul, 1 = div
mul_issue_ok  output  1  issue may send a mul op this cycle
div_issue_ok  output  1  issue may send a div op this cycle

Behaviour:
Reset and state
- Reset is asynchronous, active-low, rst_n; clock is clk.
- Per-source state: hold_v, hold_data, hold_paddr, inflight, kill. All reset to 0.
- Global state: last_grant. Resets to 1 (div), so mul wins the first tie.

Capture and latency
- A result pulse with out_valid=1 (and kill=0) is written into that source's hold register at the clock edge.
- Visible on wb_* the next cycle. Minimum latency: result pulse to wb_valid = 1 cycle.

Writeback outputs
- Combinational from the hold registers.
- wb_valid = mul_hold_v | div_hold_v.
- wb_data, wb_Paddr, wb_src come from the granted entry. When wb_valid=0 they are all 0.

Arbitration
- If only one hold entry is valid, it is granted.
- If both are valid, round-robin: grant the source not equal to last_grant.
- last_grant updates only on pop (wb_valid & wb_ready).
- Grant is stable while wb_ready=0; no re-arbitration without a pop.

Pop
- wb_valid & wb_ready clears the granted hold_v.
- A new capture from the same source in the same cycle overrides the clear: the entry refills.

In-flight tracking
- inflight set on issue_fire; cleared on out_valid of that source.
- issue_fire and out_valid in the same cycle leaves inflight set. This covers a 1-cycle unit.

Issue back-pressure
- x_issue_ok = !x_kill & (!x_hold_v | (pop & grant==x)).
- The unit holds one op at a time, so a result can never arrive while its hold entry is full.
- out_valid with hold_v=1 and no same-cycle pop is a protocol violation. The newest result overwrites the entry; the bench flags it via assertion.

Flush
- flush=1 clears both hold_v at the edge and forces wb_valid=0 in the flush cycle; no pop occurs.
- Any source with inflight=1 (or issue_fire in the flush cycle) sets kill=1 and clears inflight.
- A result arriving while kill=1 is dropped and clears kill.
- A result arriving in the flush cycle itself is dropped; kill for that source is cleared.
- issue_fire is ignored while the same source's kill=1. Issue logic must not fire then, since issue_ok=0.

Reset
- Reset mid-operation discards all state; no writeback is produced afterwards.

Optional Feature:
MUL_DIV_WB_FIXED_PRIO_EN
- Defined: fixed priority, mul always beats div when both hold entries are valid; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
1. mul_out_valid=1, mul_out=0x0000_0042, Paddr=3, wb_ready=1 -> next cycle: wb_valid=1, wb_data=0x42, wb_Paddr=3, wb_src=0; cycle after: wb_valid=0.
2. mul and div results in the same cycle (0x11/P1, 0x22/P2), wb_ready=1 -> mul written first (reset last_grant=div), div next cycle; a repeat simultaneous pair is granted div first.
3. div result 0x5/P4 held with wb_ready=0 for 3 cycles -> wb_* stable 0x5/P4; div_issue_ok=0 throughout; div_issue_ok=1 in the cycle wb_ready rises.
4. div_issue_fire, then flush 2 cycles later, then div_out_valid 0x9/P6 after 10 cycles -> no writeback; kill clears; div_issue_ok returns to 1 the cycle after the drop.
5. Hold entry full with pop and same-cycle new mul result 0x77/P7 -> entry refilled; 0x77/P7 written the next cycle.
6. MUL_DIV_WB_FIXED_PRIO_EN defined, three back-to-back simultaneous pairs -> mul granted first every time.

Source files
------------

// File: rtl/mul_div_wb_arbiter_if.sv
// Bundle of the mul/div result, issue and writeback signals around mul_div_wb_arbiter.
// The slave modport is the arbiter side; the master modport is the surrounding pipeline.
interface mul_div_wb_arbiter_if #(
   parameter int WORD_WIDTH  = 32,
   parameter int PADDR_WIDTH = 5
);
   logic                   flush;
   logic                   mul_issue_fire;
   logic                   div_issue_fire;
   logic                   mul_out_valid;
   logic [WORD_WIDTH-1:0]  mul_out;
   logic [PADDR_WIDTH-1:0] mul_dst_Paddr;
   logic                   div_out_valid;
   logic [WORD_WIDTH-1:0]  div_out;
   logic [PADDR_WIDTH-1:0] div_dst_Paddr;
   logic                   wb_ready;
   logic                   wb_valid;
   logic [WORD_WIDTH-1:0]  wb_data;
   logic [PADDR_WIDTH-1:0] wb_Paddr;
   logic                   wb_src;
   logic                   mul_issue_ok;
   logic                   div_issue_ok;

   modport slave (
      input  flush, mul_issue_fire, div_issue_fire,
      input  mul_out_valid, mul_out, mul_dst_Paddr,
      input  div_out_valid, div_out, div_dst_Paddr,
      input  wb_ready,
      output wb_valid, wb_data, wb_Paddr, wb_src,
      output mul_issue_ok, div_issue_ok
   );

   modport master (
      output flush, mul_issue_fire, div_issue_fire,
      output mul_out_valid, mul_out, mul_dst_Paddr,
      output div_out_valid, div_out, div_dst_Paddr,
      output wb_ready,
      input  wb_valid, wb_data, wb_Paddr, wb_src,
      input  mul_issue_ok, div_issue_ok
   );
endinterface

// File: rtl/mul_div_wb_arbiter.sv
// Shares one writeback port between the multiplier and divider through 1-entry hold registers.
// Define MUL_DIV_WB_FIXED_PRIO_EN for fixed mul-over-div priority instead of round-robin.
module mul_div_wb_arbiter #(
   parameter int WORD_WIDTH  = 32,
   parameter int PADDR_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   mul_div_wb_arbiter_if.slave arb_if
);
   // Handshake: a writeback transfers in any cycle where wb_valid & wb_ready are both high;
   // wb_* stay stable and the grant stays on the same source until that transfer happens.

   logic                   mul_hold_v_q, mul_hold_v_d;
   logic [WORD_WIDTH-1:0]  mul_hold_data_q, mul_hold_data_d;
   logic [PADDR_WIDTH-1:0] mul_hold_paddr_q, mul_hold_paddr_d;
   logic                   mul_inflight_q, mul_inflight_d;
   logic                   mul_kill_q, mul_kill_d;

   logic                   div_hold_v_q, div_hold_v_d;
   logic [WORD_WIDTH-1:0]  div_hold_data_q, div_hold_data_d;
   logic [PADDR_WIDTH-1:0] div_hold_paddr_q, div_hold_paddr_d;
   logic                   div_inflight_q, div_inflight_d;
   logic                   div_kill_q, div_kill_d;

   logic                   lock_v_q, lock_v_d;
   logic                   lock_src_q, lock_src_d;
`ifndef MUL_DIV_WB_FIXED_PRIO_EN
   logic                   last_grant_q, last_grant_d;
`endif

   logic grant;
   logic wb_valid;
   logic pop;
   logic mul_issue_eff, div_issue_eff;
   logic mul_cap, div_cap;
   logic mul_pop, div_pop;

   always_comb begin
      // A stalled request keeps its source, so a late arrival on the other side cannot steal it.
      if (lock_v_q) begin
         grant = lock_src_q;
      end else if (mul_hold_v_q && div_hold_v_q) begin
`ifdef MUL_DIV_WB_FIXED_PRIO_EN
         grant = 1'b0;
`else
         grant = ~last_grant_q;
`endif
      end else begin
         grant = div_hold_v_q;
      end

      wb_valid = (mul_hold_v_q | div_hold_v_q) & ~arb_if.flush;
      pop      = wb_valid & arb_if.wb_ready;
      mul_pop  = pop & ~grant;
      div_pop  = pop & grant;

      mul_issue_eff = arb_if.mul_issue_fire & ~mul_kill_q;
      div_issue_eff = arb_if.div_issue_fire & ~div_kill_q;
      mul_cap       = arb_if.mul_out_valid & ~mul_kill_q & ~arb_if.flush;
      div_cap       = arb_if.div_out_valid & ~div_kill_q & ~arb_if.flush;

      // Capture wins over a same-cycle pop so the entry refills.
      mul_hold_v_d     = ~arb_if.flush & (mul_cap | (mul_hold_v_q & ~mul_pop));
      mul_hold_data_d  = mul_cap ? arb_if.mul_out : mul_hold_data_q;
      mul_hold_paddr_d = mul_cap ? arb_if.mul_dst_Paddr : mul_hold_paddr_q;
      div_hold_v_d     = ~arb_if.flush & (div_cap | (div_hold_v_q & ~div_pop));
      div_hold_data_d  = div_cap ? arb_if.div_out : div_hold_data_q;
      div_hold_paddr_d = div_cap ? arb_if.div_dst_Paddr : div_hold_paddr_q;

      mul_inflight_d = ~arb_if.flush & (mul_issue_eff | (mul_inflight_q & ~arb_if.mul_out_valid));
      div_inflight_d = ~arb_if.flush & (div_issue_eff | (div_inflight_q & ~arb_if.div_out_valid));

      // Kill marks an op whose result must be dropped; the result that finally arrives retires it.
      if (arb_if.flush) begin
         mul_kill_d = mul_issue_eff | ((mul_inflight_q | mul_kill_q) & ~arb_if.mul_out_valid);
         div_kill_d = div_issue_eff | ((div_inflight_q | div_kill_q) & ~arb_if.div_out_valid);
      end else begin
         mul_kill_d = mul_kill_q & ~arb_if.mul_out_valid;
         div_kill_d = div_kill_q & ~arb_if.div_out_valid;
      end

      lock_v_d   = wb_valid & ~arb_if.wb_ready;
      lock_src_d = grant;
`ifndef MUL_DIV_WB_FIXED_PRIO_EN
      last_grant_d = pop ? grant : last_grant_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_hold_v_q     <= 1'b0;
         mul_hold_data_q  <= '0;
         mul_hold_paddr_q <= '0;
         mul_inflight_q   <= 1'b0;
         mul_kill_q       <= 1'b0;
         div_hold_v_q     <= 1'b0;
         div_hold_data_q  <= '0;
         div_hold_paddr_q <= '0;
         div_inflight_q   <= 1'b0;
         div_kill_q       <= 1'b0;
         lock_v_q         <= 1'b0;
         lock_src_q       <= 1'b0;
`ifndef MUL_DIV_WB_FIXED_PRIO_EN
         last_grant_q     <= 1'b1;
`endif
      end else begin
         mul_hold_v_q     <= mul_hold_v_d;
         mul_hold_data_q  <= mul_hold_data_d;
         mul_hold_paddr_q <= mul_hold_paddr_d;
         mul_inflight_q   <= mul_inflight_d;
         mul_kill_q       <= mul_kill_d;
         div_hold_v_q     <= div_hold_v_d;
         div_hold_data_q  <= div_hold_data_d;
         div_hold_paddr_q <= div_hold_paddr_d;
         div_inflight_q   <= div_inflight_d;
         div_kill_q       <= div_kill_d;
         lock_v_q         <= lock_v_d;
         lock_src_q       <= lock_src_d;
`ifndef MUL_DIV_WB_FIXED_PRIO_EN
         last_grant_q     <= last_grant_d;
`endif
      end
   end

   assign arb_if.wb_valid     = wb_valid;
   assign arb_if.wb_src       = wb_valid & grant;
   assign arb_if.wb_data      = !wb_valid ? '0 : (grant ? div_hold_data_q : mul_hold_data_q);
   assign arb_if.wb_Paddr     = !wb_valid ? '0 : (grant ? div_hold_paddr_q : mul_hold_paddr_q);
   assign arb_if.mul_issue_ok = ~mul_kill_q & (~mul_hold_v_q | mul_pop);
   assign arb_if.div_issue_ok = ~div_kill_q & (~div_hold_v_q | div_pop);

endmodule

// File: tb/tb_mul_div_wb_arbiter.sv
// Directed scoreboard bench for mul_div_wb_arbiter: stimulus pushes expected writebacks,
// a negedge monitor pops and compares every accepted writeback.
module tb_mul_div_wb_arbiter;
  localparam int WW = 32;
  localparam int PW = 5;
  localparam int W  = 1 + PW + WW;
`ifdef MUL_DIV_WB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mul_div_wb_arbiter_if #(.WORD_WIDTH(WW), .PADDR_WIDTH(PW)) bus ();

  mul_div_wb_arbiter #(.WORD_WIDTH(WW), .PADDR_WIDTH(PW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus)
  );

  function automatic logic [W-1:0] pack(input logic src, input logic [PW-1:0] p, input logic [WW-1:0] d);
    return {src, p, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush          = 1'b0;
    bus.mul_issue_fire = 1'b0;
    bus.div_issue_fire = 1'b0;
    bus.mul_out_valid  = 1'b0;
    bus.mul_out        = '0;
    bus.mul_dst_Paddr  = '0;
    bus.div_out_valid  = 1'b0;
    bus.div_out        = '0;
    bus.div_dst_Paddr  = '0;
  endtask

  task automatic mul_res(input logic [WW-1:0] d, input logic [PW-1:0] p);
    bus.mul_out_valid = 1'b1;
    bus.mul_out       = d;
    bus.mul_dst_Paddr = p;
  endtask

  task automatic div_res(input logic [WW-1:0] d, input logic [PW-1:0] p);
    bus.div_out_valid = 1'b1;
    bus.div_out       = d;
    bus.div_dst_Paddr = p;
  endtask

  // Drives a simultaneous pair and queues the two writebacks in the order they must appear.
  task automatic pair(input logic [WW-1:0] md, input logic [PW-1:0] mp,
                      input logic [WW-1:0] dd, input logic [PW-1:0] dp, input bit mul_first);
    mul_res(md, mp);
    div_res(dd, dp);
    if (mul_first) begin
      exp_q.push_back(pack(1'b0, mp, md));
      exp_q.push_back(pack(1'b1, dp, dd));
    end else begin
      exp_q.push_back(pack(1'b1, dp, dd));
      exp_q.push_back(pack(1'b0, mp, md));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = pack(bus.wb_src, bus.wb_Paddr, bus.wb_data);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wb_unexpected: got src=%0d paddr=%0d data=0x%0h, required no writeback",
                 got[W-1], got[W-2:WW], got[WW-1:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_errors++;
          $display("FAIL wb_beat: got src=%0d paddr=%0d data=0x%0h, required src=%0d paddr=%0d data=0x%0h",
                   got[W-1], got[W-2:WW], got[WW-1:0], exp[W-1], exp[W-2:WW], exp[WW-1:0]);
        end
      end
    end
  end

  // A result may only land in a full entry if that entry is popped in the same cycle.
  always @(negedge clk) begin
    if (rst_n && !bus.flush) begin
      assert (!(bus.mul_out_valid && !dut.mul_kill_q && dut.mul_hold_v_q &&
                !(bus.wb_valid && bus.wb_ready && !bus.wb_src)))
        else $error("mul result overwrote a full hold entry");
      assert (!(bus.div_out_valid && !dut.div_kill_q && dut.div_hold_v_q &&
                !(bus.wb_valid && bus.wb_ready && bus.wb_src)))
        else $error("div result overwrote a full hold entry");
    end
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.wb_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check("reset_wb_valid", bus.wb_valid, 0);
    check("reset_wb_data", bus.wb_data, 0);
    check("reset_mul_issue_ok", bus.mul_issue_ok, 1);
    check("reset_div_issue_ok", bus.div_issue_ok, 1);
    step();
    rst_n = 1'b1;
    step();

    // Simultaneous pair right after reset: mul wins the first tie.
    pair(32'h11, 5'd1, 32'h22, 5'd2, 1'b1);
    step();
    idle();
    @(negedge clk);
    check("pair1_first_src", bus.wb_src, 0);
    step();
    @(negedge clk);
    check("pair1_second_src", bus.wb_src, 1);
    step();
    @(negedge clk);
    check("pair1_drained", bus.wb_valid, 0);

    // Single mul result: one cycle latency, then idle.
    mul_res(32'h42, 5'd3);
    exp_q.push_back(pack(1'b0, 5'd3, 32'h42));
    step();
    idle();
    @(negedge clk);
    check("single_wb_valid", bus.wb_valid, 1);
    check("single_wb_data", bus.wb_data, 32'h42);
    check("single_wb_paddr", bus.wb_Paddr, 3);
    check("single_wb_src", bus.wb_src, 0);
    step();
    @(negedge clk);
    check("single_idle_after", bus.wb_valid, 0);

    // Repeat pair after mul was last granted: div goes first under round-robin.
    pair(32'h33, 5'd8, 32'h44, 5'd9, FIXED);
    step();
    idle();
    @(negedge clk);
    check("pair2_first_src", bus.wb_src, FIXED ? 0 : 1);
    step();
    step();

    // Three back-to-back pairs; each new pair lands as the previous second beat pops.
    for (int k = 0; k < 3; k++) begin
      pair(32'h100 + k, 5'(10 + k), 32'h200 + k, 5'(20 + k), FIXED);
      step();
      idle();
      @(negedge clk);
      check("b2b_first_src", bus.wb_src, FIXED ? 0 : 1);
      step();
    end
    step();
    @(negedge clk);
    check("b2b_drained", bus.wb_valid, 0);

    // Pop with same-cycle refill of the mul entry.
    bus.wb_ready = 1'b0;
    mul_res(32'h66, 5'd5);
    exp_q.push_back(pack(1'b0, 5'd5, 32'h66));
    step();
    idle();
    bus.wb_ready = 1'b1;
    mul_res(32'h77, 5'd7);
    exp_q.push_back(pack(1'b0, 5'd7, 32'h77));
    @(negedge clk);
    check("refill_mul_issue_ok", bus.mul_issue_ok, 1);
    step();
    idle();
    @(negedge clk);
    check("refill_wb_data", bus.wb_data, 32'h77);
    check("refill_wb_paddr", bus.wb_Paddr, 7);
    step();
    @(negedge clk);
    check("refill_drained", bus.wb_valid, 0);

    // Div result stalled by wb_ready=0 for three cycles.
    bus.wb_ready = 1'b0;
    div_res(32'h5, 5'd4);
    exp_q.push_back(pack(1'b1, 5'd4, 32'h5));
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_wb_valid", bus.wb_valid, 1);
      check("stall_wb_data", bus.wb_data, 32'h5);
      check("stall_wb_paddr", bus.wb_Paddr, 4);
      check("stall_div_issue_ok", bus.div_issue_ok, 0);
      step();
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    check("stall_release_div_issue_ok", bus.div_issue_ok, 1);
    step();
    @(negedge clk);
    check("stall_drained", bus.wb_valid, 0);

    // Flush kills an in-flight div op and discards a held mul result.
    bus.div_issue_fire = 1'b1;
    @(negedge clk);
    check("flush_pre_div_issue_ok", bus.div_issue_ok, 1);
    step();
    idle();
    bus.wb_ready = 1'b0;
    mul_res(32'h99, 5'd9);
    step();
    idle();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_wb_valid", bus.wb_valid, 0);
    step();
    idle();
    bus.wb_ready = 1'b1;
    @(negedge clk);
    check("flush_after_wb_valid", bus.wb_valid, 0);
    check("flush_kill_div_issue_ok", bus.div_issue_ok, 0);
    check("flush_mul_issue_ok", bus.mul_issue_ok, 1);
    repeat (9) step();
    div_res(32'h9, 5'd6);
    @(negedge clk);
    check("flush_drop_cycle_div_issue_ok", bus.div_issue_ok, 0);
    step();
    idle();
    @(negedge clk);
    check("flush_dropped_wb_valid", bus.wb_valid, 0);
    check("flush_kill_cleared_div_issue_ok", bus.div_issue_ok, 1);
    step();

    // Reset while a result is held: nothing is written back afterwards.
    bus.wb_ready = 1'b0;
    mul_res(32'h55, 5'd11);
    step();
    idle();
    @(negedge clk);
    check("rst_mid_held", bus.wb_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wb_valid", bus.wb_valid, 0);
    step();
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_after_wb_valid", bus.wb_valid, 0);
    step();
    step();

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
